// File: rtl/fifo_burst_reader.sv
// Read-side controller for fifo_unit: drains the FIFO in fixed-length bursts
// into a registered valid/ready stream, with a flush path for short residual bursts.
module fifo_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  f_rd,
  input  logic [DATA_WIDTH-1:0] f_r_data,
  input  logic                  f_empty,
  input  logic                  f_full,
  input  logic [ADDR_WIDTH-1:0] f_wr_ptr,
  input  logic [ADDR_WIDTH-1:0] f_rd_ptr,
  input  logic                  enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   level,
  output logic [15:0]           burst_cnt
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] BLEN  = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic [ADDR_WIDTH:0]   rem;
  logic                  flush_pend;
  logic [ADDR_WIDTH-1:0] ptr_diff;
  logic                  pop;

  // Equal pointers are ambiguous between empty and full; f_full disambiguates.
  assign ptr_diff = f_wr_ptr - f_rd_ptr;
  assign level    = f_full ? DEPTH : {1'b0, ptr_diff};

  assign pop  = (state == BURST) && !f_empty && (!m_valid || m_ready) && !reset;
  assign f_rd = pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      flush_pend <= 1'b0;
      busy       <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      if (pop) begin
        m_data  <= f_r_data;
        m_valid <= 1'b1;
        m_last  <= (rem == ONE);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (m_valid && m_ready && m_last) begin
        burst_cnt <= burst_cnt + 16'd1;
      end

      // A normal burst wins over a pending flush; the flush stays pending.
      case (state)
        IDLE: begin
          if (enable && (level >= BLEN)) begin
            state <= BURST;
            busy  <= 1'b1;
            rem   <= BLEN;
          end else if (flush_pend) begin
            flush_pend <= 1'b0;
            if (level != '0) begin
              state <= BURST;
              busy  <= 1'b1;
              rem   <= level;
            end
          end
        end
        BURST: begin
          if (pop) begin
            rem <= rem - ONE;
            if (rem == ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Placed last so a pulse arriving while an older request is consumed is kept.
      if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural first-word
// fall-through FIFO model standing in for fifo_unit.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       f_rd;
  logic [7:0] f_r_data;
  logic       f_empty;
  logic       f_full;
  logic [2:0] f_wr_ptr;
  logic [2:0] f_rd_ptr;
  logic       enable;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic [3:0] level;
  logic [15:0] burst_cnt;

  logic [7:0] mem [8];
  logic [2:0] wr_ptr = '0;
  logic [2:0] rd_ptr = '0;
  logic       full   = 1'b0;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       do_wr;

  logic       ovr;
  logic [2:0] ovr_wr;
  logic [2:0] ovr_rd;
  logic       ovr_full;

  logic [8:0] rxq [$];
  int         stampq [$];
  int         cycle = 0;
  int         rd_cnt = 0;
  int         bp_viol = 0;
  int         empty_viol = 0;
  int         checks = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .f_rd(f_rd), .f_r_data(f_r_data),
    .f_empty(f_empty), .f_full(f_full), .f_wr_ptr(f_wr_ptr), .f_rd_ptr(f_rd_ptr),
    .enable(enable), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .level(level),
    .burst_cnt(burst_cnt)
  );

  // FIFO model: not reset with the DUT, so unread words survive a reader reset.
  assign do_wr    = wr_en && (!full || f_rd);
  assign f_r_data = mem[rd_ptr];
  assign f_empty  = !full && (wr_ptr == rd_ptr);
  assign f_full   = ovr ? ovr_full : full;
  assign f_wr_ptr = ovr ? ovr_wr : wr_ptr;
  assign f_rd_ptr = ovr ? ovr_rd : rd_ptr;

  always @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 3'd1;
    end
    if (f_rd) begin
      rd_ptr <= rd_ptr + 3'd1;
    end
    if (do_wr && !f_rd) begin
      full <= ((wr_ptr + 3'd1) == rd_ptr);
    end else if (!do_wr && f_rd) begin
      full <= 1'b0;
    end
  end

  // Inputs change #1 after posedge, so the negedge sees what the next edge will.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (!reset && m_valid && m_ready) begin
      rxq.push_back({m_last, m_data});
      stampq.push_back(cycle);
    end
    if (f_rd) rd_cnt <= rd_cnt + 1;
    if (f_rd && m_valid && !m_ready) bp_viol <= bp_viol + 1;
    if (f_rd && f_empty) empty_viol <= empty_viol + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic fl, input logic rdy);
    @(posedge clk);
    #1;
    wr_en   = w;
    wr_data = d;
    flush   = fl;
    m_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, rdy);
  endtask

  initial begin
    logic rdy;
    logic found;
    logic busy_seen;
    logic [7:0] t3_words [8];
    logic [7:0] t6_words [4];
    t6_words = '{8'd30, 8'd55, 8'd16, 8'd111};

    reset = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    ovr = 1'b0; ovr_wr = '0; ovr_rd = '0; ovr_full = 1'b0;

    // Reset
    idle(2, 1'b0);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_f_rd", {31'd0, f_rd}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_burst_cnt", {16'd0, burst_cnt}, 32'd0);
    reset = 1'b0;

    // Threshold: three words stay put, the fourth triggers the burst
    $display("[TB] threshold burst");
    enable = 1'b1;
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd8, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b1);
    idle(3, 1'b1);
    checkOutput("t2_no_rd", rd_cnt, 32'd0);
    checkOutput("t2_level3", {28'd0, level}, 32'd3);
    rxq.delete(); stampq.delete();
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b1);
    idle(12, 1'b1);
    checkOutput("t2_count", rxq.size(), 32'd4);
    checkOutput("t2_w0", {23'd0, rxq[0]}, {23'd0, 1'b0, 8'd5});
    checkOutput("t2_w1", {23'd0, rxq[1]}, {23'd0, 1'b0, 8'd8});
    checkOutput("t2_w2", {23'd0, rxq[2]}, {23'd0, 1'b0, 8'd2});
    checkOutput("t2_w3", {23'd0, rxq[3]}, {23'd0, 1'b1, 8'd0});
    checkOutput("t2_consecutive", stampq[3] - stampq[0], 32'd3);
    checkOutput("t2_burst_cnt", {16'd0, burst_cnt}, 32'd1);
    checkOutput("t2_empty", {31'd0, f_empty}, 32'd1);

    // Full FIFO drained under alternating backpressure
    $display("[TB] full fifo with backpressure");
    enable = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(20 + i), 1'b0, 1'b1);
    idle(1, 1'b1);
    checkOutput("t3_full", {31'd0, f_full}, 32'd1);
    checkOutput("t3_level8", {28'd0, level}, 32'd8);
    rxq.delete(); stampq.delete();
    rd_cnt = 0; bp_viol = 0; empty_viol = 0;
    enable = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, rdy);
      rdy = ~rdy;
    end
    idle(2, 1'b1);
    t3_words = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27};
    checkOutput("t3_count", rxq.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3_w%0d", i), {23'd0, rxq[i]},
                  {23'd0, (i == 3 || i == 7), t3_words[i]});
    end
    checkOutput("t3_rd_cnt", rd_cnt, 32'd8);
    checkOutput("t3_backpressure", bp_viol, 32'd0);
    checkOutput("t3_rd_when_empty", empty_viol, 32'd0);
    checkOutput("t3_burst_cnt", {16'd0, burst_cnt}, 32'd3);

    // Flush releases a short burst; a flush with nothing stored does nothing
    $display("[TB] flush");
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
    idle(3, 1'b1);
    checkOutput("t4_level2", {28'd0, level}, 32'd2);
    checkOutput("t4_idle_busy", {31'd0, busy}, 32'd0);
    rxq.delete(); stampq.delete();
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    idle(10, 1'b1);
    checkOutput("t4_count", rxq.size(), 32'd2);
    checkOutput("t4_w0", {23'd0, rxq[0]}, {23'd0, 1'b0, 8'd7});
    checkOutput("t4_w1", {23'd0, rxq[1]}, {23'd0, 1'b1, 8'd5});
    checkOutput("t4_burst_cnt", {16'd0, burst_cnt}, 32'd4);
    rxq.delete(); rd_cnt = 0;
    busy_seen = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      busy_seen = busy_seen | busy;
    end
    checkOutput("t4_empty_flush_busy", {31'd0, busy_seen}, 32'd0);
    checkOutput("t4_empty_flush_rd", rd_cnt, 32'd0);
    checkOutput("t4_empty_flush_cnt", {16'd0, burst_cnt}, 32'd4);

    // Pointer wrap and the full/empty ambiguity of equal pointers
    $display("[TB] pointer wrap");
    enable = 1'b0;
    ovr = 1'b1; ovr_wr = 3'd1; ovr_rd = 3'd6; ovr_full = 1'b0;
    #1 checkOutput("t5_wrap", {28'd0, level}, 32'd3);
    ovr_wr = 3'd5; ovr_rd = 3'd5; ovr_full = 1'b1;
    #1 checkOutput("t5_full", {28'd0, level}, 32'd8);
    ovr_full = 1'b0;
    #1 checkOutput("t5_empty", {28'd0, level}, 32'd0);
    ovr = 1'b0;

    // Reset in the cycle 9 is handed over: 30 must stay in the FIFO
    $display("[TB] reset mid-burst");
    enable = 1'b1;
    rxq.delete();
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd30, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd55, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      if (m_valid && m_data == 8'd9) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t6_saw_9", {31'd0, found}, 32'd1);
    checkOutput("t6_first_10", {23'd0, rxq[0]}, {23'd0, 1'b0, 8'd10});
    reset = 1'b1;
    #1 checkOutput("t6_rd_gated", {31'd0, f_rd}, 32'd0);
    applyStimulus(1'b1, 8'd16, 1'b0, 1'b1);
    checkOutput("t6_valid_cleared", {31'd0, m_valid}, 32'd0);
    checkOutput("t6_busy_cleared", {31'd0, busy}, 32'd0);
    checkOutput("t6_rd_in_reset", {31'd0, f_rd}, 32'd0);
    applyStimulus(1'b1, 8'd111, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    rxq.delete();
    reset = 1'b0;
    idle(12, 1'b1);
    checkOutput("t6_count", rxq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t6_w%0d", i), {23'd0, rxq[i]},
                  {23'd0, (i == 3), t6_words[i]});
    end
    checkOutput("t6_burst_cnt", {16'd0, burst_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
